// File: rtl/fcc_cluster_stats_if.sv
// Stream bundle for the cluster statistics stage: the labelled point input,
// the cluster record output and the end-of-frame summary.
interface fcc_cluster_stats_if #(
    parameter int LABEL_W = 16,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 5,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [ROW_W-1:0]   in_row;
    logic [COL_W-1:0]   in_col;
    logic [LABEL_W-1:0] in_label;
    logic               in_last;

    logic               out_valid;
    logic               out_ready;
    logic [LABEL_W-1:0] out_label;
    logic [CNT_W-1:0]   out_count;
    logic [ROW_W-1:0]   out_row_min;
    logic [ROW_W-1:0]   out_row_max;
    logic [COL_W-1:0]   out_col_min;
    logic [COL_W-1:0]   out_col_max;

    logic               frame_done;
    logic [IDX_W:0]     frame_clusters;
    logic [CNT_W-1:0]   overflow_cnt;

    // Producer/consumer side (the environment around the stage)
    modport master (
        output in_valid, in_row, in_col, in_label, in_last, out_ready,
        input  in_ready, out_valid, out_label, out_count,
               out_row_min, out_row_max, out_col_min, out_col_max,
               frame_done, frame_clusters, overflow_cnt
    );

    // The statistics stage itself
    modport slave (
        input  in_valid, in_row, in_col, in_label, in_last, out_ready,
        output in_ready, out_valid, out_label, out_count,
               out_row_min, out_row_max, out_col_min, out_col_max,
               frame_done, frame_clusters, overflow_cnt
    );
endinterface

// File: rtl/fcc_cluster_stats.sv
// Cluster statistics stage: accumulates per-label point count and bounding
// box over one frame, then scans the table and emits every label with at
// least MIN_PTS points, followed by a one-cycle frame summary.
module fcc_cluster_stats #(
    parameter int LABEL_W    = 16,
    parameter int ROW_W      = 8,
    parameter int COL_W      = 5,
    parameter int NUM_LABELS = 32,
    parameter int IDX_W      = 5,
    parameter int CNT_W      = 10,
    parameter int MIN_PTS    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fcc_cluster_stats_if.slave    bus
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] idx;
    logic             scan_done;

    // Per-label table; min/max are only meaningful once count is non-zero,
    // so only the count needs clearing between frames.
    logic [CNT_W-1:0] cnt_tab  [NUM_LABELS];
    logic [ROW_W-1:0] rmin_tab [NUM_LABELS];
    logic [ROW_W-1:0] rmax_tab [NUM_LABELS];
    logic [COL_W-1:0] cmin_tab [NUM_LABELS];
    logic [COL_W-1:0] cmax_tab [NUM_LABELS];

    logic               out_valid_q;
    logic [LABEL_W-1:0] out_label_q;
    logic [CNT_W-1:0]   out_count_q;
    logic [ROW_W-1:0]   out_row_min_q;
    logic [ROW_W-1:0]   out_row_max_q;
    logic [COL_W-1:0]   out_col_min_q;
    logic [COL_W-1:0]   out_col_max_q;
    logic [IDX_W:0]     frame_clusters_q;
    logic [CNT_W-1:0]   overflow_cnt_q;

    logic             in_ready_c;
    logic             frame_done_c;
    logic             accept_in;
    logic             label_ok;
    logic [IDX_W-1:0] entry;
    logic             last_idx;
    logic             stall;
    logic             rec_accept;
    logic             qualify;
    logic             scan_step;

    assign accept_in  = bus.in_valid && in_ready_c;
    assign label_ok   = bus.in_label < LABEL_W'(NUM_LABELS);
    assign entry      = bus.in_label[IDX_W-1:0];
    assign last_idx   = (idx == IDX_W'(NUM_LABELS - 1));
    assign stall      = out_valid_q && !bus.out_ready;
    assign rec_accept = out_valid_q && bus.out_ready;
    assign qualify    = (cnt_tab[idx] >= CNT_W'(MIN_PTS));
    assign scan_step  = (state == SCAN) && !scan_done && !stall;

    assign bus.in_ready       = in_ready_c;
    assign bus.frame_done     = frame_done_c;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_label      = out_label_q;
    assign bus.out_count      = out_count_q;
    assign bus.out_row_min    = out_row_min_q;
    assign bus.out_row_max    = out_row_max_q;
    assign bus.out_col_min    = out_col_min_q;
    assign bus.out_col_max    = out_col_max_q;
    assign bus.frame_clusters = frame_clusters_q;
    assign bus.overflow_cnt   = overflow_cnt_q;

    // State register; reset always restarts with a full table clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the purely state-derived outputs
    always_comb begin
        state_nxt    = state;
        in_ready_c   = 1'b0;
        frame_done_c = 1'b0;
        case (state)
            CLEAR: begin
                if (last_idx) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_done && (!out_valid_q || rec_accept)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done_c = 1'b1;
                state_nxt    = CLEAR;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Table index walker shared by the clear and scan passes
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            scan_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= last_idx ? '0 : idx + IDX_W'(1);
                end
                ACCUM: begin
                    idx       <= '0;
                    scan_done <= 1'b0;
                end
                SCAN: begin
                    if (scan_step) begin
                        if (last_idx) begin
                            scan_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    idx       <= '0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

    // Table maintenance: clear one count per cycle, or fold in an accepted
    // point as a single-cycle read-modify-write so repeated labels are safe
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                cnt_tab[idx] <= '0;
            end else if (accept_in && label_ok) begin
                if (cnt_tab[entry] == '0) begin
                    cnt_tab[entry]  <= CNT_W'(1);
                    rmin_tab[entry] <= bus.in_row;
                    rmax_tab[entry] <= bus.in_row;
                    cmin_tab[entry] <= bus.in_col;
                    cmax_tab[entry] <= bus.in_col;
                end else begin
                    if (cnt_tab[entry] != '1) begin
                        cnt_tab[entry] <= cnt_tab[entry] + CNT_W'(1);
                    end
                    if (bus.in_row < rmin_tab[entry]) begin
                        rmin_tab[entry] <= bus.in_row;
                    end
                    if (bus.in_row > rmax_tab[entry]) begin
                        rmax_tab[entry] <= bus.in_row;
                    end
                    if (bus.in_col < cmin_tab[entry]) begin
                        cmin_tab[entry] <= bus.in_col;
                    end
                    if (bus.in_col > cmax_tab[entry]) begin
                        cmax_tab[entry] <= bus.in_col;
                    end
                end
            end
        end
    end

    // Record output register: load a qualifying entry while the scan is
    // moving, otherwise drop valid once the consumer has taken the record
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_label_q   <= '0;
            out_count_q   <= '0;
            out_row_min_q <= '0;
            out_row_max_q <= '0;
            out_col_min_q <= '0;
            out_col_max_q <= '0;
        end else if (scan_step && qualify) begin
            out_valid_q   <= 1'b1;
            out_label_q   <= LABEL_W'(idx);
            out_count_q   <= cnt_tab[idx];
            out_row_min_q <= rmin_tab[idx];
            out_row_max_q <= rmax_tab[idx];
            out_col_min_q <= cmin_tab[idx];
            out_col_max_q <= cmax_tab[idx];
        end else if (rec_accept) begin
            out_valid_q <= 1'b0;
        end
    end

    // Frame summary counters; they stay readable through DONE and CLEAR and
    // restart when the next frame opens
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_clusters_q <= '0;
            overflow_cnt_q   <= '0;
        end else if (state == CLEAR) begin
            if (last_idx) begin
                frame_clusters_q <= '0;
                overflow_cnt_q   <= '0;
            end
        end else begin
            if (rec_accept) begin
                frame_clusters_q <= frame_clusters_q + (IDX_W+1)'(1);
            end
            if (accept_in && !label_ok && (overflow_cnt_q != '1)) begin
                overflow_cnt_q <= overflow_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fcc_cluster_stats.sv
// Self-checking bench for fcc_cluster_stats: directed frame table, multi-cycle
// corner sequences and randomized frames against a behavioural model.
module tb_fcc_cluster_stats;

    localparam int NL      = 32;
    localparam int CNT_MAX = 1023;
    localparam int MINP    = 3;

    typedef struct {
        int label;
        int count;
        int rmin;
        int rmax;
        int cmin;
        int cmax;
    } rec_t;

    typedef struct {
        int               npts;
        logic [7:0][7:0]  rows;
        logic [7:0][4:0]  cols;
        logic [7:0][15:0] labels;
        int               expLabel;
        int               expCount;
        int               expRmin;
        int               expRmax;
        int               expCmin;
        int               expCmax;
        int               expClusters;
        int               expOvf;
    } frame_vec_t;

    logic clk;
    logic rst;

    fcc_cluster_stats_if bus ();

    fcc_cluster_stats dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total;
    int   bad;
    rec_t expQ[$];
    int   expClusters;
    int   expOvf;
    int   qRow[$];
    int   qCol[$];
    int   qLabel[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one point and hold it until the stage takes it
    task automatic applyStimulus(input int row, input int col, input int label, input bit last);
        bit accepted;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_row   = 8'(row);
        bus.in_col   = 5'(col);
        bus.in_label = 16'(label);
        bus.in_last  = last;
        for (int c = 0; c < 200 && !accepted; c++) begin
            if (bus.in_ready) begin
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Consume records until frame_done; mode 0 always ready, 1 random,
    // 2 hold each record back for five cycles
    task automatic collectRecords(input int mode);
        bit done;
        int stallCnt;
        done     = 1'b0;
        stallCnt = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.out_valid && stallCnt < 5) begin
                        bus.out_ready = 1'b0;
                        stallCnt++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_record_label", int'(bus.out_label), -1);
                end else begin
                    checkOutput("out_label", int'(bus.out_label), expQ[0].label);
                    checkOutput("out_count", int'(bus.out_count), expQ[0].count);
                    checkOutput("out_row_min", int'(bus.out_row_min), expQ[0].rmin);
                    checkOutput("out_row_max", int'(bus.out_row_max), expQ[0].rmax);
                    checkOutput("out_col_min", int'(bus.out_col_min), expQ[0].cmin);
                    checkOutput("out_col_max", int'(bus.out_col_max), expQ[0].cmax);
                    if (bus.out_ready) begin
                        void'(expQ.pop_front());
                        stallCnt = 0;
                    end
                end
            end
            if (bus.frame_done) begin
                done = 1'b1;
                checkOutput("records_missing_at_done", expQ.size(), 0);
                checkOutput("frame_clusters", int'(bus.frame_clusters), expClusters);
                checkOutput("overflow_cnt", int'(bus.overflow_cnt), expOvf);
            end
        end
        if (!done) begin
            checkOutput("frame_done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("frame_done_pulse_width", int'(bus.frame_done), 0);
        end
        bus.out_ready = 1'b1;
        expQ.delete();
    endtask

    // Reference: tally each label directly, clamp counts at the end
    task automatic modelFrame();
        int cnt[NL];
        int rmin[NL];
        int rmax[NL];
        int cmin[NL];
        int cmax[NL];
        rec_t r;
        expQ.delete();
        expOvf      = 0;
        expClusters = 0;
        for (int l = 0; l < NL; l++) begin
            cnt[l] = 0;
        end
        for (int i = 0; i < qRow.size(); i++) begin
            if (qLabel[i] >= NL) begin
                expOvf = (expOvf < CNT_MAX) ? expOvf + 1 : CNT_MAX;
            end else if (cnt[qLabel[i]] == 0) begin
                cnt[qLabel[i]]  = 1;
                rmin[qLabel[i]] = qRow[i];
                rmax[qLabel[i]] = qRow[i];
                cmin[qLabel[i]] = qCol[i];
                cmax[qLabel[i]] = qCol[i];
            end else begin
                cnt[qLabel[i]]++;
                if (qRow[i] < rmin[qLabel[i]]) rmin[qLabel[i]] = qRow[i];
                if (qRow[i] > rmax[qLabel[i]]) rmax[qLabel[i]] = qRow[i];
                if (qCol[i] < cmin[qLabel[i]]) cmin[qLabel[i]] = qCol[i];
                if (qCol[i] > cmax[qLabel[i]]) cmax[qLabel[i]] = qCol[i];
            end
        end
        for (int l = 0; l < NL; l++) begin
            r.count = (cnt[l] > CNT_MAX) ? CNT_MAX : cnt[l];
            if (r.count >= MINP) begin
                r.label = l;
                r.rmin  = rmin[l];
                r.rmax  = rmax[l];
                r.cmin  = cmin[l];
                r.cmax  = cmax[l];
                expQ.push_back(r);
                expClusters++;
            end
        end
    endtask

    task automatic sendQueued();
        int n;
        n = qRow.size();
        for (int i = 0; i < n; i++) begin
            applyStimulus(qRow[i], qCol[i], qLabel[i], i == n - 1);
        end
        qRow.delete();
        qCol.delete();
        qLabel.delete();
    endtask

    task automatic runFrame(input int mode);
        modelFrame();
        sendQueued();
        collectRecords(mode);
    endtask

    task automatic queuePoint(input int row, input int col, input int label);
        qRow.push_back(row);
        qCol.push_back(col);
        qLabel.push_back(label);
    endtask

    frame_vec_t vecs[3];

    initial begin
        rec_t r;
        int   clearCycles;
        bit   seen;

        total = 0;
        bad   = 0;

        // Directed frames: label 5 alone, suppressed small label, overflow label
        vecs[0].npts = 3;
        vecs[0].rows[0] = 8'd2;  vecs[0].cols[0] = 5'd3; vecs[0].labels[0] = 16'd5;
        vecs[0].rows[1] = 8'd4;  vecs[0].cols[1] = 5'd1; vecs[0].labels[1] = 16'd5;
        vecs[0].rows[2] = 8'd3;  vecs[0].cols[2] = 5'd7; vecs[0].labels[2] = 16'd5;
        vecs[0].expLabel = 5; vecs[0].expCount = 3; vecs[0].expRmin = 2; vecs[0].expRmax = 4;
        vecs[0].expCmin = 1; vecs[0].expCmax = 7; vecs[0].expClusters = 1; vecs[0].expOvf = 0;

        vecs[1].npts = 6;
        vecs[1].rows[0] = 8'd0;  vecs[1].cols[0] = 5'd0; vecs[1].labels[0] = 16'd1;
        vecs[1].rows[1] = 8'd1;  vecs[1].cols[1] = 5'd1; vecs[1].labels[1] = 16'd1;
        vecs[1].rows[2] = 8'd5;  vecs[1].cols[2] = 5'd2; vecs[1].labels[2] = 16'd9;
        vecs[1].rows[3] = 8'd6;  vecs[1].cols[3] = 5'd3; vecs[1].labels[3] = 16'd9;
        vecs[1].rows[4] = 8'd7;  vecs[1].cols[4] = 5'd4; vecs[1].labels[4] = 16'd9;
        vecs[1].rows[5] = 8'd8;  vecs[1].cols[5] = 5'd5; vecs[1].labels[5] = 16'd9;
        vecs[1].expLabel = 9; vecs[1].expCount = 4; vecs[1].expRmin = 5; vecs[1].expRmax = 8;
        vecs[1].expCmin = 2; vecs[1].expCmax = 5; vecs[1].expClusters = 1; vecs[1].expOvf = 0;

        vecs[2].npts = 4;
        vecs[2].rows[0] = 8'd9;  vecs[2].cols[0] = 5'd9; vecs[2].labels[0] = 16'd40;
        vecs[2].rows[1] = 8'd10; vecs[2].cols[1] = 5'd4; vecs[2].labels[1] = 16'd7;
        vecs[2].rows[2] = 8'd12; vecs[2].cols[2] = 5'd2; vecs[2].labels[2] = 16'd7;
        vecs[2].rows[3] = 8'd11; vecs[2].cols[3] = 5'd6; vecs[2].labels[3] = 16'd7;
        vecs[2].expLabel = 7; vecs[2].expCount = 3; vecs[2].expRmin = 10; vecs[2].expRmax = 12;
        vecs[2].expCmin = 2; vecs[2].expCmax = 6; vecs[2].expClusters = 1; vecs[2].expOvf = 1;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.in_col    = '0;
        bus.in_label  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset_in_ready", int'(bus.in_ready), 0);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_frame_done", int'(bus.frame_done), 0);
        checkOutput("reset_frame_clusters", int'(bus.frame_clusters), 0);
        checkOutput("reset_overflow_cnt", int'(bus.overflow_cnt), 0);
        checkOutput("reset_out_count", int'(bus.out_count), 0);
        rst = 1'b0;

        $display("[TB] directed frame table");
        for (int t = 0; t < 3; t++) begin
            for (int p = 0; p < vecs[t].npts; p++) begin
                applyStimulus(int'(vecs[t].rows[p]), int'(vecs[t].cols[p]),
                              int'(vecs[t].labels[p]), p == vecs[t].npts - 1);
            end
            r.label = vecs[t].expLabel;
            r.count = vecs[t].expCount;
            r.rmin  = vecs[t].expRmin;
            r.rmax  = vecs[t].expRmax;
            r.cmin  = vecs[t].expCmin;
            r.cmax  = vecs[t].expCmax;
            expQ.push_back(r);
            expClusters = vecs[t].expClusters;
            expOvf      = vecs[t].expOvf;
            collectRecords(0);
        end

        $display("[TB] three clusters with five-cycle backpressure");
        for (int k = 0; k < 3; k++) begin
            queuePoint($urandom_range(0, 255), $urandom_range(0, 31), 0);
            queuePoint($urandom_range(0, 255), $urandom_range(0, 31), 10);
            queuePoint($urandom_range(0, 255), $urandom_range(0, 31), 31);
        end
        runFrame(2);

        $display("[TB] count saturation");
        for (int i = 0; i < 1030; i++) begin
            applyStimulus(10 + (i % 20), i % 32, 2, i == 1029);
        end
        r.label = 2; r.count = 1023; r.rmin = 10; r.rmax = 29; r.cmin = 0; r.cmax = 31;
        expQ.push_back(r);
        expClusters = 1;
        expOvf      = 0;
        collectRecords(0);

        $display("[TB] empty frame");
        queuePoint(1, 1, 4);
        queuePoint(2, 2, 50);
        runFrame(0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(20, 80);
            for (int i = 0; i < n; i++) begin
                queuePoint($urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 35));
            end
            runFrame(1);
        end

        $display("[TB] reset during scan");
        for (int i = 0; i < 3; i++) begin
            queuePoint(20 + i, 3 + i, 3);
            queuePoint(40 + i, 9, 20);
        end
        bus.out_ready = 1'b0;
        sendQueued();
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        checkOutput("rst_scan_out_valid_before", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_scan_out_valid_after", int'(bus.out_valid), 0);
        checkOutput("rst_scan_in_ready_after", int'(bus.in_ready), 0);
        checkOutput("rst_scan_frame_clusters", int'(bus.frame_clusters), 0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        clearCycles   = 0;
        while (!bus.in_ready && clearCycles < 200) begin
            clearCycles++;
            @(negedge clk);
        end
        checkOutput("rst_clear_cycles", clearCycles, 32);
        queuePoint(7, 30, 3);
        queuePoint(5, 28, 3);
        queuePoint(6, 31, 3);
        queuePoint(100, 0, 20);
        runFrame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcc_cluster_stats.md
Name: fcc_cluster_stats

Overview:
Downstream stage of the connected-components labeller. It consumes the labelled non-ground point stream (row, col, root label) for one frame. For each label it accumulates the point count and the row/col bounding box. At end of frame it scans the table and emits one record per cluster with at least MIN_PTS points. It then reports a frame summary and clears itself for the next frame.

Parameters:
LABEL_W, 16, width of incoming root label
ROW_W, 8, row index width
COL_W, 5, column index width
NUM_LABELS, 32, number of table entries (labels 0..NUM_LABELS-1 tracked)
IDX_W, 5, table index width, equals clog2(NUM_LABELS)
CNT_W, 10, per-label point counter width
MIN_PTS, 3, minimum count for a cluster to be emitted

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  labelled point present
in_ready  out  1  stage can accept a point
in_row  in  ROW_W  point row
in_col  in  COL_W  point column
in_label  in  LABEL_W  root label of point
in_last  in  1  final point of frame (qualified by in_valid && in_ready)
out_valid  out  1  cluster record valid
out_ready  in  1  consumer accepts record
out_label  out  LABEL_W  cluster label (zero-extended index)
out_count  out  CNT_W  points in cluster
out_row_min  out  ROW_W  bounding box min row
out_row_max  out  ROW_W  bounding box max row
out_col_min  out  COL_W  bounding box min col
out_col_max  out  COL_W  bounding box max col
frame_done  out  1  one-cycle pulse after the scan completes
frame_clusters  out  IDX_W+1  number of records emitted this frame, valid with frame_done
overflow_cnt  out  CNT_W  points dropped this frame (label >= NUM_LABELS), valid with frame_done

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - state goes to CLEAR;
  - all outputs are 0, including in_ready=0, out_valid=0, frame_done=0;
  - overflow_cnt and frame_clusters are 0;
  - reset mid-frame or mid-scan discards everything.
- Table: NUM_LABELS entries of {count, row_min, row_max, col_min, col_max}, held in flops.
- CLEAR:
  - idx steps 0..NUM_LABELS-1, zeroing count, one entry per cycle (NUM_LABELS cycles);
  - in_ready=0;
  - then go to ACCUM and zero the overflow/cluster counters.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - If in_label < NUM_LABELS, entry e = in_label[IDX_W-1:0] is updated in the same edge:
    - count=0 → count=1, min=max=point;
    - otherwise count+1, saturating at 2^CNT_W-1, with min/max updated by unsigned compare.
  - Back-to-back beats on the same label must accumulate correctly, with no hazard.
  - If in_label >= NUM_LABELS, the point is dropped and overflow_cnt increments (saturating).
  - An accepted beat with in_last=1 is accumulated and the state moves to SCAN on the next cycle.
- SCAN:
  - in_ready=0.
  - idx steps 0..NUM_LABELS-1, one entry per cycle, while not stalled.
  - If count >= MIN_PTS, the output registers load the entry and out_valid=1 on the next cycle.
  - The scan stalls while out_valid && !out_ready; output data is held stable.
  - Handshake: on out_valid && out_ready, out_valid drops unless the next qualifying entry loads in the same edge. Back-to-back records at full rate are allowed.
  - frame_clusters increments per accepted record.
- DONE:
  - entered after the last index is scanned and the final record is accepted;
  - frame_done=1 for exactly one cycle with final frame_clusters and overflow_cnt;
  - then CLEAR.
- Frame latency: end of frame to first record is at most NUM_LABELS+1 cycles. Turnaround to in_ready=1 is at most 2*NUM_LABELS+3 cycles, absent backpressure.
- in_valid outside ACCUM is ignored; upstream must hold data until in_ready.
- Empty frame (in_last on a label >= NUM_LABELS, or no qualifying labels): zero records, then the frame_done pulse with frame_clusters=0.

Test Plan:
1. After reset, send label 5 at points (2,3),(4,1),(3,7), last on the third → one record: label=5, count=3, rows 2..4, cols 1..7; frame_done with frame_clusters=1.
2. Label 1 ×2 and label 9 ×4, last on the final point → only the label 9 record (count=4); label 1 is suppressed; frame_clusters=1.
3. Labels 40, 7, 7, 7, last on the final point → label 7 record count=3; overflow_cnt=1 at frame_done.
4. Three qualifying labels (0, 10, 31) with out_ready low for 5 cycles on each record → records arrive in index order, data stable during stall, frame_done only after the third accept.
5. 1030 points on label 2 (CNT_W=10) → out_count=1023 (saturated).
6. rst asserted mid-SCAN while out_valid=1 → out_valid=0 next cycle; CLEAR lasts 32 cycles with in_ready=0; a following 3-point frame yields correct fresh stats with no stale entries.
